// File: rtl/btn_evt_pkg.sv
// btn_evt_pkg: shared state type, counter sizing and parameter legality
// helpers for button_event_decoder and its cycle counter.
package btn_evt_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS1    = 3'd1,
    WAIT2     = 3'd2,
    PRESS2    = 3'd3,
    LONG_HELD = 3'd4
  } state_t;

  // Smallest values for which the gesture timing still makes sense.
  localparam int MIN_LONG_PRESS_CYCLES = 2;
  localparam int MIN_DOUBLE_GAP_CYCLES = 1;
  localparam int MIN_REPEAT_CYCLES     = 1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // Bits needed so the largest terminal count is representable.
  function automatic int cnt_width(input int a, input int b, input int c);
    return $clog2(max3(a, b, c) + 1);
  endfunction

  function automatic bit params_legal(input int long_cycles, input int gap_cycles,
                                      input int repeat_cycles);
    return (long_cycles >= MIN_LONG_PRESS_CYCLES) &&
           (gap_cycles >= MIN_DOUBLE_GAP_CYCLES) &&
           (repeat_cycles >= MIN_REPEAT_CYCLES);
  endfunction

endpackage

// File: rtl/btn_cycle_counter.sv
// btn_cycle_counter: saturating, loadable up-counter with a compare that
// reports whether the next increment reaches the supplied terminal count.
module btn_cycle_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         inc,
  input  logic [W-1:0] term,
  output logic [W-1:0] count,
  output logic         reach
);

  localparam logic [W-1:0] MAX_COUNT = '1;

  logic [W-1:0] count_inc;

  assign count_inc = (count == MAX_COUNT) ? count : count + W'(1);
  assign reach     = (count_inc >= term);

  // Load has priority over increment; increments stop at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (inc) begin
      count <= count_inc;
    end
  end

endmodule

// File: rtl/button_event_decoder.sv
// button_event_decoder: classifies the debounced button level into short
// press, long press and double click pulses, plus a held level.
// Optional macro BTN_AUTOREPEAT_EN enables periodic repeat pulses while held;
// without it o_Repeat_Pulse is tied low and REPEAT_CYCLES is ignored.
module button_event_decoder
  import btn_evt_pkg::*;
#(
  parameter int LONG_PRESS_CYCLES = 8,
  parameter int DOUBLE_GAP_CYCLES = 5,
  parameter int REPEAT_CYCLES     = 4
) (
  input  logic i_Clk,
  input  logic i_Rst_n,
  input  logic i_Debounced,
  output logic o_Short_Pulse,
  output logic o_Long_Pulse,
  output logic o_Double_Pulse,
  output logic o_Held,
  output logic o_Repeat_Pulse
);

`ifdef BTN_AUTOREPEAT_EN
  localparam int CNT_W = cnt_width(LONG_PRESS_CYCLES, DOUBLE_GAP_CYCLES, REPEAT_CYCLES);
  localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CYCLES);
`else
  localparam int CNT_W = cnt_width(LONG_PRESS_CYCLES, DOUBLE_GAP_CYCLES, 1);
`endif
  localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_PRESS_CYCLES);
  localparam logic [CNT_W-1:0] GAP_TC  = CNT_W'(DOUBLE_GAP_CYCLES);

  if (!params_legal(LONG_PRESS_CYCLES, DOUBLE_GAP_CYCLES, REPEAT_CYCLES)) begin : g_param_check
    $error("button_event_decoder: illegal LONG/DOUBLE_GAP/REPEAT cycle parameters");
  end

  state_t           state;
  logic             armed;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_value;
  logic             cnt_inc;
  logic [CNT_W-1:0] cnt_term;
  logic [CNT_W-1:0] count;
  logic             cnt_reach;

  btn_cycle_counter #(
    .W(CNT_W)
  ) u_counter (
    .clk       (i_Clk),
    .rst_n     (i_Rst_n),
    .load      (cnt_load),
    .load_value(cnt_load_value),
    .inc       (cnt_inc),
    .term      (cnt_term),
    .count     (count),
    .reach     (cnt_reach)
  );

  // Terminal count depends only on which timing the current state measures.
`ifdef BTN_AUTOREPEAT_EN
  assign cnt_term = (state == WAIT2)     ? GAP_TC :
                    (state == LONG_HELD) ? REPEAT_TC : LONG_TC;
`else
  assign cnt_term = (state == WAIT2) ? GAP_TC : LONG_TC;
`endif

  // Counter control: reload on every state change, otherwise count samples.
  always_comb begin
    cnt_load       = 1'b0;
    cnt_load_value = '0;
    cnt_inc        = 1'b0;
    case (state)
      IDLE: begin
        if (armed && i_Debounced) begin
          cnt_load       = 1'b1;
          cnt_load_value = CNT_W'(1);
        end
      end
      PRESS1: begin
        if (i_Debounced) begin
          if (cnt_reach) cnt_load = 1'b1;
          else           cnt_inc  = 1'b1;
        end else if (count < LONG_TC) begin
          cnt_load       = 1'b1;
          cnt_load_value = CNT_W'(1);
        end
      end
      WAIT2: begin
        if (i_Debounced || cnt_reach) cnt_load = 1'b1;
        else                          cnt_inc  = 1'b1;
      end
      PRESS2: begin
        if (!i_Debounced) cnt_load = 1'b1;
      end
      LONG_HELD: begin
`ifdef BTN_AUTOREPEAT_EN
        if (!i_Debounced || cnt_reach) cnt_load = 1'b1;
        else                           cnt_inc  = 1'b1;
`else
        if (!i_Debounced) cnt_load = 1'b1;
`endif
      end
      default: cnt_load = 1'b1;
    endcase
  end

`ifdef BTN_AUTOREPEAT_EN
  logic repeat_pulse;
  assign o_Repeat_Pulse = repeat_pulse;
`else
  assign o_Repeat_Pulse = 1'b0;
`endif

  // Gesture FSM with registered pulses; arming waits for a released button.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state          <= IDLE;
      armed          <= 1'b0;
      o_Short_Pulse  <= 1'b0;
      o_Long_Pulse   <= 1'b0;
      o_Double_Pulse <= 1'b0;
      o_Held         <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      repeat_pulse   <= 1'b0;
`endif
    end else begin
      o_Short_Pulse  <= 1'b0;
      o_Long_Pulse   <= 1'b0;
      o_Double_Pulse <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      repeat_pulse   <= 1'b0;
`endif
      if (!i_Debounced) armed <= 1'b1;
      case (state)
        IDLE: begin
          if (armed && i_Debounced) state <= PRESS1;
        end
        PRESS1: begin
          if (i_Debounced) begin
            if (cnt_reach) begin
              state        <= LONG_HELD;
              o_Long_Pulse <= 1'b1;
              o_Held       <= 1'b1;
            end
          end else if (count < LONG_TC) begin
            state <= WAIT2;
          end
        end
        WAIT2: begin
          if (i_Debounced) begin
            state <= PRESS2;
          end else if (cnt_reach) begin
            state         <= IDLE;
            o_Short_Pulse <= 1'b1;
          end
        end
        PRESS2: begin
          if (!i_Debounced) begin
            state          <= IDLE;
            o_Double_Pulse <= 1'b1;
          end
        end
        LONG_HELD: begin
          if (!i_Debounced) begin
            state  <= IDLE;
            o_Held <= 1'b0;
          end
`ifdef BTN_AUTOREPEAT_EN
          else if (cnt_reach) begin
            repeat_pulse <= 1'b1;
          end
`endif
        end
        default: begin
          state  <= IDLE;
          o_Held <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_event_decoder.sv
// tb_button_event_decoder: drives directed and random button gestures and
// compares every cycle against a run-length based gesture classifier.
// Honors BTN_AUTOREPEAT_EN the same way the design does.
module tb_button_event_decoder;

  localparam int LONG = 8;
  localparam int GAP  = 5;
  localparam int REP  = 4;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic debounced = 1'b0;
  logic short_p, long_p, double_p, held, repeat_p;

  int errors = 0;
  int checks = 0;

  // Reference model state: armed flag and run lengths of the open gesture
  // (even index = high run, odd index = low run).
  bit m_armed = 1'b0;
  int runs[$];
  bit stim[$];

  button_event_decoder #(
    .LONG_PRESS_CYCLES(LONG),
    .DOUBLE_GAP_CYCLES(GAP),
    .REPEAT_CYCLES    (REP)
  ) dut (
    .i_Clk         (clk),
    .i_Rst_n       (rst_n),
    .i_Debounced   (debounced),
    .o_Short_Pulse (short_p),
    .o_Long_Pulse  (long_p),
    .o_Double_Pulse(double_p),
    .o_Held        (held),
    .o_Repeat_Pulse(repeat_p)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Output vector layout: {short, long, double, repeat, held}.
  function automatic logic [4:0] observed();
    return {short_p, long_p, double_p, repeat_p, held};
  endfunction

  function automatic void model_reset();
    m_armed = 1'b0;
    runs.delete();
  endfunction

  // Classify the open gesture from its run lengths after one more sample.
  function automatic logic [4:0] model_step(input bit d);
    logic [4:0] e;
    int n;
    bit last_high;
    e = '0;
    if (!m_armed) begin
      if (!d) m_armed = 1'b1;
      return e;
    end
    if (runs.size() == 0) begin
      if (d) runs.push_back(1);
      return e;
    end
    last_high = (runs.size() % 2) == 1;
    if (d == last_high) runs[runs.size()-1] = runs[runs.size()-1] + 1;
    else                runs.push_back(1);
    n = runs.size();
    if (n == 1) begin
      if (runs[0] == LONG) e[3] = 1'b1;
      else if (AR && runs[0] > LONG && ((runs[0] - LONG) % REP) == 0) e[1] = 1'b1;
      e[0] = (runs[0] >= LONG);
    end else if (runs[0] >= LONG) begin
      runs.delete();
    end else if (n == 2 && runs[1] == GAP) begin
      e[4] = 1'b1;
      runs.delete();
    end else if (n == 4) begin
      e[2] = 1'b1;
      runs.delete();
    end
    return e;
  endfunction

  function automatic void add_run(input bit lv, input int n);
    for (int i = 0; i < n; i++) stim.push_back(lv);
  endfunction

  // Present one sample for the next rising edge and step the model with it.
  task automatic drive(input bit d, output logic [4:0] e);
    @(negedge clk);
    debounced = d;
    e = model_step(d);
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    logic [4:0] e;
    for (int i = 0; i < 8; i++) drive(1'b0, e);
  endtask

  task automatic test_reset();
    logic [4:0] e, obs;
    int pulses = 0;
    int shorts = 0;
    rst_n = 1'b0;
    debounced = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (observed() !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %b expected %b", observed(), 5'b0);
    end
    #1 rst_n = 1'b1;
    stim.delete();
    add_run(1'b1, 20); add_run(1'b0, 1); add_run(1'b1, 3); add_run(1'b0, 6);
    for (int i = 0; i < stim.size(); i++) begin
      drive(stim[i], e);
      obs = observed();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("[TB] FAIL reset_cycle%0d: got %b expected %b", i, obs, e);
      end
      if (i < 21 && obs != 5'b0) pulses++;
      if (obs[4]) shorts++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("[TB] FAIL held_through_reset: got %0d events expected 0", pulses);
    end
    checks++;
    if (shorts != 1) begin
      errors++;
      $display("[TB] FAIL rearm_short: got %0d short pulses expected 1", shorts);
    end
  endtask

  task automatic test_short_press();
    logic [4:0] e, obs;
    int short_at = 0;
    int shorts = 0;
    int others = 0;
    settle();
    stim.delete();
    add_run(1'b1, 3); add_run(1'b0, 7);
    for (int i = 0; i < stim.size(); i++) begin
      drive(stim[i], e);
      obs = observed();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("[TB] FAIL short_cycle%0d: got %b expected %b", i, obs, e);
      end
      if (obs[4]) begin shorts++; short_at = i + 1; end
      if (obs[3:0] != 4'b0) others++;
    end
    checks++;
    if (shorts != 1 || short_at != 8) begin
      errors++;
      $display("[TB] FAIL short_timing: got %0d pulses at sample %0d expected 1 at 8", shorts, short_at);
    end
    checks++;
    if (others != 0) begin
      errors++;
      $display("[TB] FAIL short_others: got %0d other events expected 0", others);
    end
  endtask

  task automatic test_long_press();
    logic [4:0] e, obs;
    int long_at = 0;
    int held_first = 0;
    int held_last = 0;
    int extra = 0;
    settle();
    stim.delete();
    add_run(1'b1, 10); add_run(1'b0, 6);
    for (int i = 0; i < stim.size(); i++) begin
      drive(stim[i], e);
      obs = observed();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("[TB] FAIL long_cycle%0d: got %b expected %b", i, obs, e);
      end
      if (obs[3]) long_at = i + 1;
      if (obs[0]) begin
        if (held_first == 0) held_first = i + 1;
        held_last = i + 1;
      end
      if (obs[4] || obs[2] || obs[1]) extra++;
    end
    checks++;
    if (long_at != 8) begin
      errors++;
      $display("[TB] FAIL long_timing: got sample %0d expected 8", long_at);
    end
    checks++;
    if (held_first != 8 || held_last != 10) begin
      errors++;
      $display("[TB] FAIL held_window: got %0d..%0d expected 8..10", held_first, held_last);
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("[TB] FAIL long_release: got %0d extra pulses expected 0", extra);
    end
  endtask

  task automatic test_double_click();
    logic [4:0] e, obs;
    int double_at = 0;
    int shorts = 0;
    settle();
    stim.delete();
    add_run(1'b1, 2); add_run(1'b0, 2); add_run(1'b1, 3); add_run(1'b0, 7);
    for (int i = 0; i < stim.size(); i++) begin
      drive(stim[i], e);
      obs = observed();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("[TB] FAIL double_cycle%0d: got %b expected %b", i, obs, e);
      end
      if (obs[2]) double_at = i + 1;
      if (obs[4]) shorts++;
    end
    checks++;
    if (double_at != 8 || shorts != 0) begin
      errors++;
      $display("[TB] FAIL double_timing: got sample %0d shorts %0d expected 8 and 0", double_at, shorts);
    end
  endtask

  task automatic test_gap_boundary();
    logic [4:0] e, obs;
    int shorts = 0;
    int doubles = 0;
    int double_at = 0;
    settle();
    stim.delete();
    add_run(1'b1, 2); add_run(1'b0, 5); add_run(1'b1, 2); add_run(1'b0, 5);
    add_run(1'b1, 2); add_run(1'b0, 4); add_run(1'b1, 1); add_run(1'b0, 6);
    for (int i = 0; i < stim.size(); i++) begin
      drive(stim[i], e);
      obs = observed();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("[TB] FAIL gap_cycle%0d: got %b expected %b", i, obs, e);
      end
      if (obs[4]) shorts++;
      if (obs[2]) begin doubles++; double_at = i + 1; end
    end
    checks++;
    if (shorts != 2 || doubles != 1 || double_at != 22) begin
      errors++;
      $display("[TB] FAIL gap_boundary: got shorts %0d doubles %0d at %0d expected 2, 1 at 22",
               shorts, doubles, double_at);
    end
  endtask

  task automatic test_autorepeat();
    logic [4:0] e, obs;
    int repeats = 0;
    int first_repeat = 0;
    int long_at = 0;
    settle();
    stim.delete();
    add_run(1'b1, 20); add_run(1'b0, 6);
    for (int i = 0; i < stim.size(); i++) begin
      drive(stim[i], e);
      obs = observed();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("[TB] FAIL repeat_cycle%0d: got %b expected %b", i, obs, e);
      end
      if (obs[3]) long_at = i + 1;
      if (obs[1]) begin
        repeats++;
        if (first_repeat == 0) first_repeat = i + 1;
      end
    end
    checks++;
    if (long_at != 8 || repeats != (AR ? 3 : 0) || first_repeat != (AR ? 12 : 0)) begin
      errors++;
      $display("[TB] FAIL repeat_count: got long %0d repeats %0d first %0d expected 8, %0d, %0d",
               long_at, repeats, first_repeat, AR ? 3 : 0, AR ? 12 : 0);
    end
  endtask

  task automatic test_reset_mid_hold();
    logic [4:0] e, obs;
    int shorts = 0;
    settle();
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, e);
      obs = observed();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("[TB] FAIL hold_cycle%0d: got %b expected %b", i, obs, e);
      end
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (observed() !== 5'b0) begin
      errors++;
      $display("[TB] FAIL async_reset: got %b expected %b", observed(), 5'b0);
    end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    stim.delete();
    add_run(1'b1, 5); add_run(1'b0, 1); add_run(1'b1, 3); add_run(1'b0, 6);
    for (int i = 0; i < stim.size(); i++) begin
      drive(stim[i], e);
      obs = observed();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("[TB] FAIL post_reset_cycle%0d: got %b expected %b", i, obs, e);
      end
      if (obs[4]) shorts++;
    end
    checks++;
    if (shorts != 1) begin
      errors++;
      $display("[TB] FAIL post_reset_short: got %0d expected 1", shorts);
    end
  endtask

  task automatic test_random();
    logic [4:0] e, obs;
    bit lv = 1'b1;
    int n;
    settle();
    for (int g = 0; g < 400; g++) begin
      n = lv ? $urandom_range(1, 14) : $urandom_range(1, 7);
      for (int i = 0; i < n; i++) begin
        drive(lv, e);
        obs = observed();
        checks++;
        if (obs !== e) begin
          errors++;
          $display("[TB] FAIL random_g%0d_s%0d: got %b expected %b", g, i, obs, e);
        end
        checks++;
        if ($countones(obs[4:1]) > 1) begin
          errors++;
          $display("[TB] FAIL exclusive_g%0d: got %b expected at most one pulse", g, obs);
        end
      end
      lv = ~lv;
    end
  endtask

  initial begin
    $display("[TB] button_event_decoder bench, autorepeat=%0d", AR);
    test_reset();
    test_short_press();
    test_long_press();
    test_double_click();
    test_gap_boundary();
    test_autorepeat();
    test_reset_mid_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
